// File: rtl/rv32i_types.sv
// Shared types for the register scoreboard.
//   sb_cnt_t   : 2-bit in-flight counter (pend or ld)
//   SB_MAX     : saturation value of a counter
//   sb_entry_t : per-register counter pair {pend, ld}
//   cnt_next   : next value of a counter given increment/decrement requests
package rv32i_types;

  typedef logic [1:0] sb_cnt_t;

  localparam sb_cnt_t SB_MAX = 2'd3;

  typedef struct packed {
    sb_cnt_t pend;
    sb_cnt_t ld;
  } sb_entry_t;

  // Simultaneous inc+dec cancels. The counter holds at SB_MAX on overflow
  // and holds at 0 on underflow; the caller flags underflow separately.
  function automatic sb_cnt_t cnt_next(input sb_cnt_t c, input logic inc, input logic dec);
    sb_cnt_t r;
    r = c;
    case ({inc, dec})
      2'b10:   r = (c == SB_MAX) ? c : c + 2'd1;
      2'b01:   r = (c == 2'd0) ? c : c - 2'd1;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One tracked register: in-flight writer count (pend) and in-flight load
// count (ld).
//   clk_i, rst_i       : clock, async active-high reset
//   flush_i            : zero both counters, overrides all other requests
//   inc_pend_i/inc_ld_i: issue of a writer / load to this register
//   dec_pend_i/dec_ld_i: writeback / load response for this register
//   pend_o, ld_o       : current counter values
//   underflow_o        : a decrement hit a counter already at 0
module scoreboard_entry
  import rv32i_types::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       inc_pend_i,
  input  logic       inc_ld_i,
  input  logic       dec_pend_i,
  input  logic       dec_ld_i,
  output logic [1:0] pend_o,
  output logic [1:0] ld_o,
  output logic       underflow_o
);

  sb_entry_t ent_q, ent_d;

  always_comb begin
    ent_d       = ent_q;
    underflow_o = 1'b0;
    if (flush_i) begin
      ent_d = '0;
    end else begin
      ent_d.pend  = cnt_next(ent_q.pend, inc_pend_i, dec_pend_i);
      ent_d.ld    = cnt_next(ent_q.ld, inc_ld_i, dec_ld_i);
      // A cancelling inc+dec nets to zero change and is not an error.
      underflow_o = (dec_pend_i && !inc_pend_i && (ent_q.pend == 2'd0)) ||
                    (dec_ld_i && !inc_ld_i && (ent_q.ld == 2'd0));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign pend_o = ent_q.pend;
  assign ld_o   = ent_q.ld;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for an in-order pipeline: tracks in-flight writers and
// loads per architectural register and stalls issue on load-use hazards or
// writer-count saturation.
//   clk_i, rst_i                  : clock, async active-high reset
//   iss_valid_i                   : decode presents an instruction
//   iss_rd_i/iss_rs1_i/iss_rs2_i  : destination / source indices
//   iss_we_i, iss_is_load_i       : writes rd / result comes from dmem
//   iss_stall_o                   : issue refused this cycle
//   wb_valid_i, wb_rd_i           : regfile write retires
//   ld_resp_valid_i, ld_resp_rd_i : load data returned
//   flush_i                       : squash all tracking state
//   rs1_busy_o, rs2_busy_o        : source has an in-flight writer
//   any_busy_o                    : any register has an in-flight writer
//   err_o                         : sticky counter-underflow error
//   stall_cnt_o                   : number of stalled cycles (wraps)
module reg_scoreboard
  import rv32i_types::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  input  logic [4:0]  iss_rs1_i,
  input  logic [4:0]  iss_rs2_i,
  input  logic        iss_we_i,
  input  logic        iss_is_load_i,
  output logic        iss_stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        ld_resp_valid_i,
  input  logic [4:0]  ld_resp_rd_i,
  input  logic        flush_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        any_busy_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  sb_cnt_t     pend_w [32];
  sb_cnt_t     ld_w   [32];
  logic [31:1] underflow_w;
  logic        iss_fire_w;
  logic        err_q, err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // x0 is never tracked and always reads idle.
  assign pend_w[0] = '0;
  assign ld_w[0]   = '0;

  for (genvar g = 1; g < 32; g++) begin : g_entry
    logic inc_pend, inc_ld, dec_pend, dec_ld;

    assign inc_pend = iss_fire_w && (iss_rd_i == 5'(g));
    assign inc_ld   = inc_pend && iss_is_load_i;
    assign dec_pend = wb_valid_i && (wb_rd_i == 5'(g));
    assign dec_ld   = ld_resp_valid_i && (ld_resp_rd_i == 5'(g));

    scoreboard_entry u_entry (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .inc_pend_i  (inc_pend),
      .inc_ld_i    (inc_ld),
      .dec_pend_i  (dec_pend),
      .dec_ld_i    (dec_ld),
      .pend_o      (pend_w[g]),
      .ld_o        (ld_w[g]),
      .underflow_o (underflow_w[g])
    );
  end

  // Pure decode of registered state: same-cycle wb/ld_resp are ignored so the
  // stall never depends on retire-side timing.
  always_comb begin
    iss_stall_o = 1'b0;
    if (iss_valid_i) begin
      iss_stall_o = (ld_w[iss_rs1_i] != 2'd0) ||
                    (ld_w[iss_rs2_i] != 2'd0) ||
                    (iss_we_i && (iss_rd_i != 5'd0) && (pend_w[iss_rd_i] == SB_MAX));
    end
  end

  // rd==0 is filtered by the per-entry decode (no entry for x0).
  assign iss_fire_w = iss_valid_i && !iss_stall_o && iss_we_i;

  assign rs1_busy_o = (pend_w[iss_rs1_i] != 2'd0);
  assign rs2_busy_o = (pend_w[iss_rs2_i] != 2'd0);

  always_comb begin
    any_busy_o = 1'b0;
    for (int i = 1; i < 32; i++) begin
      any_busy_o = any_busy_o | (pend_w[i] != 2'd0);
    end
  end

  always_comb begin
    err_d       = err_q | (|underflow_w);
    stall_cnt_d = stall_cnt_q;
    if (iss_stall_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_we, iss_is_load;
  logic        iss_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        ld_resp_valid;
  logic [4:0]  ld_resp_rd;
  logic        flush;
  logic        rs1_busy, rs2_busy, any_busy, err;
  logic [31:0] stall_cnt;

  reg_scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .iss_valid_i     (iss_valid),
    .iss_rd_i        (iss_rd),
    .iss_rs1_i       (iss_rs1),
    .iss_rs2_i       (iss_rs2),
    .iss_we_i        (iss_we),
    .iss_is_load_i   (iss_is_load),
    .iss_stall_o     (iss_stall),
    .wb_valid_i      (wb_valid),
    .wb_rd_i         (wb_rd),
    .ld_resp_valid_i (ld_resp_valid),
    .ld_resp_rd_i    (ld_resp_rd),
    .flush_i         (flush),
    .rs1_busy_o      (rs1_busy),
    .rs2_busy_o      (rs2_busy),
    .any_busy_o      (any_busy),
    .err_o           (err),
    .stall_cnt_o     (stall_cnt)
  );

  // Clock starts high so the first negedge (sampling point) precedes the first posedge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        stall;
    logic        rs1b;
    logic        rs2b;
    logic        anyb;
    logic        err;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, act, expv);
    end
  endtask

  // Monitor: every negedge with a pending expectation compares all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "iss_stall", 32'(iss_stall), 32'(e.stall));
      chk(e.name, "rs1_busy",  32'(rs1_busy),  32'(e.rs1b));
      chk(e.name, "rs2_busy",  32'(rs2_busy),  32'(e.rs2b));
      chk(e.name, "any_busy",  32'(any_busy),  32'(e.anyb));
      chk(e.name, "err",       32'(err),       32'(e.err));
      chk(e.name, "stall_cnt", stall_cnt,      e.scnt);
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic we, input logic ld, input logic wbv, input logic [4:0] wbrd,
                       input logic lv, input logic [4:0] lrd, input logic fl);
    iss_valid     = v;
    iss_rd        = rd;
    iss_rs1       = rs1;
    iss_rs2       = rs2;
    iss_we        = we;
    iss_is_load   = ld;
    wb_valid      = wbv;
    wb_rd         = wbrd;
    ld_resp_valid = lv;
    ld_resp_rd    = lrd;
    flush         = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_o(input string n, input logic s, input logic b1, input logic b2,
                          input logic ab, input logic e, input logic [31:0] sc);
    exp_t x;
    x.name = n; x.stall = s; x.rs1b = b1; x.rs2b = b2; x.anyb = ab; x.err = e; x.scnt = sc;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    // Reset: even a would-be hazardous issue shows nothing.
    drive(1, 5, 5, 5, 1, 1, 1, 5, 1, 5, 0);
    expect_o("reset", 0, 0, 0, 0, 0, 0); step();
    rst = 1'b0;

    // Load-use hazard on x5.
    drive(1, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0); expect_o("lu_issue_load", 0, 0, 0, 0, 0, 0); step();
    drive(1, 6, 5, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("lu_stall1",     1, 1, 0, 1, 0, 0); step();
    drive(1, 6, 5, 0, 1, 0, 0, 0, 1, 5, 0); expect_o("lu_stall_resp", 1, 1, 0, 1, 0, 1); step();
    drive(1, 6, 5, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("lu_fire",       0, 1, 0, 1, 0, 2); step();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0); expect_o("lu_wb5",        0, 0, 0, 1, 0, 2); step();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0); expect_o("lu_wb6",        0, 0, 0, 1, 0, 2); step();
    idle();                                 expect_o("lu_idle",       0, 0, 0, 0, 0, 2); step();

    // Forwardable ALU producer on x7.
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("alu_issue",     0, 0, 0, 0, 0, 2); step();
    drive(1, 8, 0, 7, 1, 0, 0, 0, 0, 0, 0); expect_o("alu_consumer",  0, 0, 1, 1, 0, 2); step();
    drive(0, 0, 0, 7, 0, 0, 1, 7, 0, 0, 0); expect_o("alu_wb7",       0, 0, 1, 1, 0, 2); step();
    drive(0, 0, 0, 7, 0, 0, 1, 8, 0, 0, 0); expect_o("alu_rs2_free",  0, 0, 0, 1, 0, 2); step();

    // Saturation on x9.
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sat_1",         0, 0, 0, 0, 0, 2); step();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sat_2",         0, 0, 0, 1, 0, 2); step();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sat_3",         0, 0, 0, 1, 0, 2); step();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sat_4_stall",   1, 0, 0, 1, 0, 2); step();
    drive(1, 9, 0, 0, 1, 0, 1, 9, 0, 0, 0); expect_o("sat_stall_wb",  1, 0, 0, 1, 0, 3); step();
    drive(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sat_4_fire",    0, 0, 0, 1, 0, 4); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0); expect_o("sat_drain", 0, 0, 0, 1, 0, 4); step();
    end
    idle();                                 expect_o("sat_idle",      0, 0, 0, 0, 0, 4); step();

    // Simultaneous issue and wb on x3 with pend[3]=1.
    drive(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("sim_issue",     0, 0, 0, 0, 0, 4); step();
    drive(1, 3, 3, 0, 1, 0, 1, 3, 0, 0, 0); expect_o("sim_inc_dec",   0, 1, 0, 1, 0, 4); step();
    drive(0, 0, 3, 0, 0, 0, 1, 3, 0, 0, 0); expect_o("sim_still1",    0, 1, 0, 1, 0, 4); step();
    drive(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("sim_zero",      0, 0, 0, 0, 0, 4); step();

    // x0 is never tracked.
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); expect_o("x0_issue",      0, 0, 0, 0, 0, 4); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0); expect_o("x0_retire",     0, 0, 0, 0, 0, 4); step();
    idle();                                 expect_o("x0_no_err",     0, 0, 0, 0, 0, 4); step();

    // Flush priority and post-flush underflow.
    drive(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_o("fl_issue4",     0, 0, 0, 0, 0, 4); step();
    drive(1, 10, 0, 0, 1, 1, 0, 0, 0, 0, 1); expect_o("fl_flush",     0, 0, 0, 1, 0, 4); step();
    drive(0, 0, 10, 4, 0, 0, 0, 0, 0, 0, 0); expect_o("fl_cleared",   0, 0, 0, 0, 0, 4); step();
    drive(1, 0, 10, 0, 0, 0, 1, 4, 0, 0, 0); expect_o("fl_wb4",       0, 0, 0, 0, 0, 4); step();
    idle();                                 expect_o("err_set",       0, 0, 0, 0, 1, 4); step();
    idle();                                 expect_o("err_sticky",    0, 0, 0, 0, 1, 4); step();

    // Flush during a stall leaves stall_cnt counting.
    drive(1, 11, 0, 0, 1, 1, 0, 0, 0, 0, 0); expect_o("fs_load11",    0, 0, 0, 0, 1, 4); step();
    drive(1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 1); expect_o("fs_stall_fl",  1, 1, 0, 1, 1, 4); step();
    drive(1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0); expect_o("fs_after",     0, 0, 0, 0, 1, 5); step();

    // Async reset mid-cycle.
    drive(1, 12, 0, 0, 1, 1, 0, 0, 0, 0, 0); expect_o("rst_load12",   0, 0, 0, 0, 1, 5); step();
    drive(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0); expect_o("rst_pre",      1, 0, 1, 1, 1, 5); step();
    drive(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0); expect_o("rst_async",    0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0); expect_o("rst_after",    0, 0, 0, 0, 0, 0); step();
    idle();                                 expect_o("rst_idle",      0, 0, 0, 0, 0, 0); step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 SHALL provide iss_valid input 1: decode stage presents an instruction.
REQ-003 SHALL provide iss_rd, iss_rs1, iss_rs2 inputs 5 each: destination and source register indices of the issuing instruction.
REQ-004 SHALL provide iss_we input 1 (instruction writes rd) and iss_is_load input 1 (result comes from dmem).
REQ-005 SHALL provide iss_stall output 1: issue is refused this cycle and decode must hold.
REQ-006 SHALL provide wb_valid input 1 and wb_rd input 5: a regfile write retires this cycle.
REQ-007 SHALL provide ld_resp_valid input 1 and ld_resp_rd input 5: load data returned from dmem for rd.
REQ-008 SHALL provide flush input 1: squash all tracking state.
REQ-009 SHALL provide rs1_busy and rs2_busy outputs 1 each: source has an in-flight writer.
REQ-010 SHALL provide any_busy output 1, err output 1 (sticky protocol error) and stall_cnt output 32 (stall-cycle counter).

Function
REQ-011 SHALL keep, per register 1..31, a 2-bit pend count (in-flight writers) and a 2-bit ld count (in-flight loads); register 0 SHALL never be tracked and SHALL always read as idle.
REQ-012 "Issue fires" SHALL mean iss_valid && !iss_stall; only a fired issue with iss_we && iss_rd!=0 SHALL update state.
REQ-013 On a fired write issue, pend[iss_rd] SHALL increment; if iss_is_load, ld[iss_rd] SHALL also increment; the update SHALL be visible the next cycle.
REQ-014 On wb_valid && wb_rd!=0, pend[wb_rd] SHALL decrement; on ld_resp_valid && ld_resp_rd!=0, ld[ld_resp_rd] SHALL decrement.
REQ-015 A simultaneous increment and decrement of the same counter SHALL leave it unchanged.
REQ-016 A decrement of a counter already at 0 SHALL leave it at 0 and set err, which SHALL stay set until reset.
REQ-017 iss_stall SHALL be combinational and SHALL assert when iss_valid and any of the following holds:
  - ld[iss_rs1]!=0 or ld[iss_rs2]!=0 (load-use);
  - iss_we && iss_rd!=0 && pend[iss_rd]==3 (saturation).
REQ-018 iss_stall SHALL NOT consider same-cycle wb or ld_resp decrements, so that it stays a pure state decode.
REQ-019 rs1_busy and rs2_busy SHALL equal pend[rs]!=0; any_busy SHALL be the OR of pend over registers 1..31.
REQ-020 flush SHALL zero all pend and ld counters on the next edge and SHALL take priority over same-cycle issue, wb and ld_resp; post-flush decrements hitting 0 SHALL set err per REQ-016.
REQ-021 stall_cnt SHALL increment by 1 each cycle iss_stall is high, wrap from 0xFFFFFFFF to 0, and be unaffected by flush.

Reset
REQ-022 While rst is high, all counters, err and stall_cnt SHALL be 0, independent of clk.
REQ-023 Outputs under reset SHALL be: iss_stall=0, rs1_busy=0, rs2_busy=0, any_busy=0, err=0, stall_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight tracking; no residual stall SHALL appear after deassertion.

Structure
REQ-025 rv32i_types SHALL hold the sb_cnt_t typedef (2-bit), the SB_MAX=3 constant and a struct sb_entry_t {pend, ld}.
REQ-026 The per-register counter pair with saturation and error detect SHALL be a sub-module, scoreboard_entry, instantiated 31 times.

Verification
REQ-027 Load-use: issue load rd=5; next cycle issue add rs1=5 -> iss_stall=1; ld_resp rd=5 -> iss_stall=0 the following cycle, stall_cnt=1 per stalled cycle.
REQ-028 Forwardable ALU producer: issue add rd=7, then sub rs2=7 -> iss_stall=0, rs2_busy=1; wb rd=7 -> rs2_busy=0.
REQ-029 Saturation: three write issues to rd=9 with no wb -> fourth issue to rd=9 stalls; wb rd=9 -> fourth issue fires.
REQ-030 Simultaneous events: pend[3]=1, same-cycle issue rd=3 and wb rd=3 -> pend[3] stays 1; x0 as rd/rs never stalls or busies.
REQ-031 Flush/reset/error: pend nonzero, flush -> any_busy=0 next cycle; subsequent wb rd=4 -> err=1 sticky; async rst mid-cycle -> all outputs 0 immediately.
